prog_clk_div: RTL and testbench

- Multi-channel programmable clock divider: the parametrised successor to the fixed /2, /4, /8 ripple divider.
- All channels are counter-based and run from the single input clock. There are no derived-clock flip-flops.
- Each channel takes an even or odd divisor (2..2^DIV_W-1), reprogrammable at runtime. A new divisor takes effect only at a period boundary, so no glitches or runt pulses appear on the outputs.
- Each channel also gives a one-cycle tick, for use as a clock enable by downstream logic. A global restart phase-aligns all channels.

---
 rtl/prog_clk_div_pkg.sv | 13 +
 rtl/clk_div_chan.sv | 66 ++++++
 rtl/prog_clk_div.sv | 67 ++++++
 tb/tb_prog_clk_div.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package prog_clk_div_pkg;

  localparam int DIV_W_DFLT       = 8;
  localparam int DEFAULT_DIV_DFLT = 2;
  localparam int MIN_DIV          = 2;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divisor pair and
// registered clk_out / tick outputs.
module clk_div_chan
  import prog_clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] hi_len;
  logic             wrap;

  // High phase takes the extra cycle when the divisor is odd.
  assign hi_len = active - (active >> 1);
  assign wrap   = (cnt == active - DIV_W'(1));

  // Counter, divisor swap at period boundaries and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= DIV_W'(DEFAULT_DIV);
      shadow  <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (restart || !en) begin
        // Idle/restart: park at the start of a period, pick up any staged divisor.
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else begin
        clk_out <= (cnt < hi_len);
        tick    <= (cnt == '0);
        cnt     <= wrap ? '0 : cnt + DIV_W'(1);
        if (wrap && pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end
      // A write in the same cycle as a swap stages the new value for the next boundary.
      if (cfg_wr) begin
        shadow  <= cfg_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: config decode, write validation,
// error flag and restart fan-out around NUM_CH counter-based channels.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 3,
  parameter  int DIV_W       = DIV_W_DFLT,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DFLT,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              ch_ok;
  logic              div_ok;
  logic              wr_ok;
  logic [NUM_CH-1:0] cfg_wr;

  assign ch_ok  = (32'(cfg_ch) < 32'(NUM_CH));
  assign div_ok = (cfg_div >= DIV_W'(MIN_DIV));
  assign wr_ok  = cfg_we && ch_ok && div_ok;

  // Decode an accepted write into a one-hot per-channel strobe.
  always_comb begin
    cfg_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_wr[i] = wr_ok && (32'(cfg_ch) == 32'(i));
    end
  end

  // Rejected writes flag an error one cycle later.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !(ch_ok && div_ok);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .restart (sync_restart),
      .cfg_wr  (cfg_wr[g]),
      .cfg_div (cfg_div),
      .pending (div_pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed scenarios then random traffic, every cycle
// compared against a waveform-queue reference model.
module tb_prog_clk_div;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int DEF_D  = 2;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_restart;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] div_pending;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int checks = 0;
  int passes = 0;

  prog_clk_div #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_D)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_err      (cfg_err),
    .div_pending  (div_pending),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: each channel holds the remaining samples of its current
  // output period as a queue of {clk_out, tick} pairs.
  bit [1:0]          m_q [NUM_CH][$];
  int                m_d [NUM_CH];
  int                m_sh [NUM_CH];
  bit                m_pend [NUM_CH];
  logic [NUM_CH-1:0] e_clk;
  logic [NUM_CH-1:0] e_tick;
  logic [NUM_CH-1:0] e_pend;
  logic              e_err;

  task automatic model_edge(input logic r, input logic [NUM_CH-1:0] en, input logic rs,
                            input logic we, input int ch, input int dv);
    bit       valid;
    int       hi;
    bit [1:0] s;
    if (!r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_q[i].delete();
        m_d[i]    = DEF_D;
        m_sh[i]   = DEF_D;
        m_pend[i] = 1'b0;
        e_clk[i]  = 1'b0;
        e_tick[i] = 1'b0;
        e_pend[i] = 1'b0;
      end
      e_err = 1'b0;
      return;
    end
    valid = we && (ch < NUM_CH) && (dv >= 2);
    e_err = we && !valid;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rs || !en[i]) begin
        if (m_pend[i]) m_d[i] = m_sh[i];
        m_pend[i] = 1'b0;
        m_q[i].delete();
        e_clk[i]  = 1'b0;
        e_tick[i] = 1'b0;
      end else begin
        if (m_q[i].size() == 0) begin
          hi = m_d[i] - m_d[i] / 2;
          for (int k = 0; k < m_d[i]; k++) m_q[i].push_back({(k < hi), (k == 0)});
        end
        s = m_q[i].pop_front();
        e_clk[i]  = s[1];
        e_tick[i] = s[0];
        if (m_q[i].size() == 0 && m_pend[i]) begin
          m_d[i]    = m_sh[i];
          m_pend[i] = 1'b0;
        end
      end
      if (valid && ch == i) begin
        m_sh[i]   = dv;
        m_pend[i] = 1'b1;
      end
      e_pend[i] = m_pend[i];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // One clock: capture the inputs the DUT samples, advance the model, compare.
  task automatic step();
    logic              r;
    logic [NUM_CH-1:0] en;
    logic              rs;
    logic              we;
    int                ch;
    int                dv;
    r  = rst_n;
    en = ch_en;
    rs = sync_restart;
    we = cfg_we;
    ch = int'(cfg_ch);
    dv = int'(cfg_div);
    @(posedge clk_in);
    model_edge(r, en, rs, we, ch, dv);
    #1;
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("div_pending", 32'(div_pending), 32'(e_pend));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  task automatic write(input int ch, input int dv);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(dv);
    step();
    cfg_we  = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; ch_en = '0; sync_restart = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // Reset state
    step();
    step();
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_pending", 32'(div_pending), 32'd0);

    // Default divide-by-2 after release
    rst_n = 1'b1;
    ch_en = 3'b111;
    step();
    chk("first_edge_high", 32'(clk_out), 32'h7);
    repeat (8) step();

    // Program 4/8/3 and phase-align with restart
    write(0, 4);
    write(1, 8);
    write(2, 3);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    step();
    chk("restart_aligned", 32'(clk_out), 32'h7);
    repeat (24) step();

    // Mid-period divisor change 6 -> 5
    write(0, 6);
    guard = 0;
    while (div_pending[0] && guard < 40) begin step(); guard++; end
    if (guard >= 40) timeout_fail("apply_div6");
    repeat (2) step();
    write(0, 5);
    chk("pending_after_write", 32'(div_pending[0]), 32'd1);
    repeat (20) step();

    // Write landing exactly on the wrap cycle
    write(0, 4);
    guard = 0;
    while (m_q[0].size() != 1 && guard < 40) begin step(); guard++; end
    if (guard >= 40) timeout_fail("find_wrap");
    write(0, 3);
    chk("pending_kept_on_wrap", 32'(div_pending[0]), 32'd1);
    repeat (16) step();

    // Rejected writes
    write(1, 1);
    chk("err_div_low", 32'(cfg_err), 32'd1);
    write(3, 5);
    chk("err_bad_ch", 32'(cfg_err), 32'd1);
    step();
    chk("err_clears", 32'(cfg_err), 32'd0);

    // Disable mid-high phase, re-enable, then reset mid-period
    guard = 0;
    while (!(clk_out[1] && m_q[1].size() > 5) && guard < 40) begin step(); guard++; end
    if (guard >= 40) timeout_fail("find_high");
    ch_en = 3'b101;
    step();
    chk("disable_low", 32'(clk_out[1]), 32'd0);
    ch_en = 3'b111;
    step();
    chk("reenable_high", 32'(clk_out[1]), 32'd1);
    repeat (3) step();
    write(2, 9);
    rst_n = 1'b0;
    step();
    chk("midreset_clk_out", 32'(clk_out), 32'd0);
    chk("midreset_pending", 32'(div_pending), 32'd0);
    rst_n = 1'b1;
    repeat (6) step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      sync_restart = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) ch_en = NUM_CH'($urandom_range(0, 7));
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = CH_W'($urandom_range(0, 3));
      cfg_div = ($urandom_range(0, 19) == 0) ? DIV_W'($urandom_range(0, 255))
                                             : DIV_W'($urandom_range(0, 12));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
